// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: head-end driver for the configuration flop chain.
// Shifts a marker followed by a word-streamed payload onto ccff_head, gated
// by ccff_shift_en, and checks that the marker emerges intact at ccff_tail.
// Ports:
//   prog_clk, pReset     clock, synchronous active-high reset
//   start                one-cycle pulse, begins a load from IDLE or DONE
//   s_data/s_valid/s_ready  bitstream word handshake (bit 0 shifted first)
//   ccff_head, ccff_shift_en  serial data and shift strobe into the chain
//   ccff_tail            serial data out of the chain end
//   busy, done, error    load status; error is sticky until the next start
//   bit_count            shifts issued in the current load
module ccff_bitstream_loader #(
    parameter int                CHAIN_LEN = 1024,
    parameter int                WORD_W    = 32,
    parameter int                MARK_W    = 8,
    parameter logic [MARK_W-1:0] MARKER    = 8'hA5,
    parameter int                CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  bit_count
);

    localparam int BW = $clog2(WORD_W + 1);
    localparam int FW = $clog2(CHAIN_LEN + WORD_W + 1);

    localparam logic [CNT_W-1:0] LAST_MARK  = CNT_W'(MARK_W - 1);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(MARK_W + CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] WIN_LO     = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] WIN_HI     = CNT_W'(CHAIN_LEN + MARK_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        LOAD,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0]  count;
    logic [WORD_W-1:0] data_buf;
    logic [BW-1:0]     buf_left;
    logic [FW-1:0]     fetched;
    logic              head_q;
    logic              error_q;

    logic              shift;
    logic              head_bit;
    logic              ready_c;
    logic              busy_c;
    logic              done_c;

    logic [MARK_W-1:0] mark_sh;
    logic [MARK_W-1:0] tail_sh;
    logic [CNT_W-1:0]  tail_off;
    logic              buf_empty;
    logic              buf_last;
    logic              need_more;
    logic              tail_chk;
    logic              accept;
    logic              start_go;

    // Marker bit for the current shift, and the marker bit expected back at
    // the tail; the latter is indexed by shift count only, so it stays
    // correct across stalls and when the window overlaps the marker phase.
    assign mark_sh   = MARKER >> count;
    assign tail_off  = count - WIN_LO;
    assign tail_sh   = MARKER >> tail_off;

    assign buf_empty = (buf_left == '0);
    assign buf_last  = (buf_left == BW'(1));
    // Words are only requested while payload bits remain unfetched, so the
    // tail of the final word is simply never shifted.
    assign need_more = (fetched < FW'(CHAIN_LEN));

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        shift      = 1'b0;
        head_bit   = head_q;
        ready_c    = 1'b0;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = MARK;
                end
            end
            MARK: begin
                busy_c   = 1'b1;
                shift    = 1'b1;
                head_bit = mark_sh[0];
                if (count == LAST_MARK) begin
                    // Prefetch the first word so LOAD starts without a bubble.
                    ready_c    = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                busy_c  = 1'b1;
                shift   = !buf_empty;
                ready_c = need_more && (buf_empty || buf_last);
                if (!buf_empty) begin
                    head_bit = data_buf[0];
                end
                if (shift && count == LAST_SHIFT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done_c = 1'b1;
                if (start) begin
                    state_next = MARK;
                end
            end
        endcase
    end

    assign accept   = s_valid && ready_c;
    assign start_go = start && (state == IDLE || state == DONE);
    assign tail_chk = shift && (count >= WIN_LO) && (count <= WIN_HI);

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            count    <= '0;
            data_buf <= '0;
            buf_left <= '0;
            fetched  <= '0;
            head_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            if (shift) begin
                count  <= count + 1'b1;
                head_q <= head_bit;
            end
            if (tail_chk && (ccff_tail != tail_sh[0])) begin
                error_q <= 1'b1;
            end
            if (state == LOAD && shift) begin
                data_buf <= data_buf >> 1;
                buf_left <= buf_left - 1'b1;
            end
            // A new word may land on the cycle the old one drains.
            if (accept) begin
                data_buf <= s_data;
                buf_left <= BW'(WORD_W);
                fetched  <= fetched + FW'(WORD_W);
            end
            if (state == LOAD && state_next == DONE) begin
                buf_left <= '0;
            end
            if (start_go) begin
                count    <= '0;
                error_q  <= 1'b0;
                buf_left <= '0;
                fetched  <= '0;
            end
        end
    end

    assign s_ready       = ready_c;
    assign ccff_head     = head_bit;
    assign ccff_shift_en = shift;
    assign busy          = busy_c;
    assign done          = done_c;
    assign error         = error_q;
    assign bit_count     = count;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed bench for ccff_bitstream_loader with an 8-flop chain model.
// CHAIN_LEN=8, WORD_W=4, MARK_W=4, MARKER=4'b1010, payload words 3 then C.
module tb_ccff_bitstream_loader;

    logic        prog_clk = 1'b0;
    logic        pReset;
    logic        start;
    logic [3:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        ccff_head;
    logic        ccff_shift_en;
    logic        ccff_tail;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] bit_count;

    logic [7:0]  chain = 8'h00;
    logic        tail_force0 = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0]  words [2];
    logic [15:0] hseq;
    logic [15:0] err_t;
    logic [15:0] rdy_t;
    int          nshift;
    int          nstall;
    int          stall_bad;
    logic        last_head;

    // Expected head sequence 0,1,0,1,1,1,0,0,0,0,1,1 packed LSB-first.
    localparam logic [11:0] EXP_HSEQ  = 12'hC3A;
    // s_ready expected only at t=3 (prefetch) and t=7 (last bit of word 0).
    localparam logic [11:0] EXP_RDY   = 12'h088;
    // chain[i] is flop i from ccff_head; payload bit k sits at flop 7-k.
    localparam logic [7:0]  EXP_CHAIN = 8'b1100_0011;

    always #5 prog_clk = ~prog_clk;

    always @(posedge prog_clk) begin
        if (ccff_shift_en) begin
            chain <= {chain[6:0], ccff_head};
        end
    end

    assign ccff_tail = tail_force0 ? 1'b0 : chain[7];

    ccff_bitstream_loader #(
        .CHAIN_LEN (8),
        .WORD_W    (4),
        .MARK_W    (4),
        .MARKER    (4'b1010),
        .CNT_W     (16)
    ) dut (
        .prog_clk      (prog_clk),
        .pReset        (pReset),
        .start         (start),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (ccff_tail),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .bit_count     (bit_count)
    );

    task automatic step();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic run_load(input int gap, input int rst_at,
                            input int start_at, output bit hit_rst);
        int wi;
        int gl;
        bit gon;
        bit acc;
        hit_rst   = 1'b0;
        wi        = 0;
        gl        = gap;
        gon       = 1'b0;
        nshift    = 0;
        nstall    = 0;
        stall_bad = 0;
        hseq      = '0;
        err_t     = '0;
        rdy_t     = '0;
        s_data    = words[0];
        s_valid   = 1'b1;
        start     = 1'b1;
        step();
        start     = 1'b0;
        last_head = ccff_head;
        for (int c = 0; c < 60 && !done; c++) begin
            if (int'(bit_count) == rst_at) begin
                hit_rst = 1'b1;
                break;
            end
            start = (start_at >= 0 && int'(bit_count) == start_at);
            if (ccff_shift_en) begin
                if (nshift < 16) hseq[nshift] = ccff_head;
                rdy_t[bit_count[3:0]] = s_ready;
                nshift++;
            end else begin
                nstall++;
                if (ccff_head !== last_head) stall_bad++;
            end
            last_head = ccff_head;
            err_t[bit_count[3:0]] = error;
            if (wi == 1 && gl > 0 && (s_ready || gon)) begin
                s_valid = 1'b0;
                gon     = 1'b1;
                gl--;
            end else begin
                s_valid = (wi < 2);
            end
            acc = s_valid && s_ready;
            step();
            if (acc) begin
                wi++;
                if (wi < 2) s_data = words[wi];
            end
        end
        start   = 1'b0;
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        pReset  = 1'b1;
        start   = 1'b1;
        s_valid = 1'b1;
        s_data  = 4'hF;
        step();
        step();
        n_tests++;
        if ({s_ready, ccff_head, ccff_shift_en, busy, done, error} !== 6'b0
            || bit_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy%b head%b sh%b busy%b done%b err%b cnt%0d want all 0",
                     s_ready, ccff_head, ccff_shift_en, busy, done, error, bit_count);
        end
        pReset  = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        step();
        n_tests++;
        if (busy !== 1'b0 || ccff_shift_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_beats_start: busy=%b shift_en=%b want 0 0",
                     busy, ccff_shift_en);
        end
    endtask

    task automatic check_end(input string tag, input logic exp_err);
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0 || ccff_shift_en !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done: done=%b busy=%b sh=%b want 1 0 0",
                     tag, done, busy, ccff_shift_en);
        end
        n_tests++;
        if (bit_count !== 16'd12) begin
            n_fail++;
            $display("FAIL %s_count: got %0d want 12", tag, bit_count);
        end
        n_tests++;
        if (error !== exp_err) begin
            n_fail++;
            $display("FAIL %s_error: got %b want %b", tag, error, exp_err);
        end
        n_tests++;
        if (chain !== EXP_CHAIN) begin
            n_fail++;
            $display("FAIL %s_chain: got %b want %b", tag, chain, EXP_CHAIN);
        end
    endtask

    task automatic test_nominal();
        bit h;
        run_load(0, -1, -1, h);
        n_tests++;
        if (hseq[11:0] !== EXP_HSEQ || nshift != 12) begin
            n_fail++;
            $display("FAIL nominal_head_seq: got %h (%0d shifts) want %h (12)",
                     hseq[11:0], nshift, EXP_HSEQ);
        end
        n_tests++;
        if (nstall != 0) begin
            n_fail++;
            $display("FAIL nominal_stalls: got %0d want 0", nstall);
        end
        n_tests++;
        if (rdy_t[11:0] !== EXP_RDY) begin
            n_fail++;
            $display("FAIL nominal_s_ready: got %h want %h", rdy_t[11:0], EXP_RDY);
        end
        check_end("nominal", 1'b0);
        n_tests++;
        if (s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL done_s_ready: got %b want 0", s_ready);
        end
    endtask

    task automatic test_stalls();
        bit h;
        run_load(3, -1, -1, h);
        n_tests++;
        if (nstall != 3 || stall_bad != 0) begin
            n_fail++;
            $display("FAIL stall_count: got %0d stalls, %0d head changes want 3, 0",
                     nstall, stall_bad);
        end
        n_tests++;
        if (hseq[11:0] !== EXP_HSEQ || nshift != 12) begin
            n_fail++;
            $display("FAIL stall_head_seq: got %h want %h", hseq[11:0], EXP_HSEQ);
        end
        check_end("stall", 1'b0);
    endtask

    task automatic test_broken_chain();
        bit h;
        tail_force0 = 1'b1;
        run_load(0, -1, -1, h);
        // Tail 0 matches MARKER[0] at t=8; t=9 expects 1 and mismatches.
        n_tests++;
        if (err_t[9:8] !== 2'b00 || err_t[11:10] !== 2'b11) begin
            n_fail++;
            $display("FAIL broken_err_timing: err[11:8]=%b want 1100", err_t[11:8]);
        end
        check_end("broken", 1'b1);
        tail_force0 = 1'b0;
    endtask

    task automatic test_restart_in_done();
        start = 1'b1;
        step();
        start = 1'b0;
        n_tests++;
        if (done !== 1'b0 || error !== 1'b0 || bit_count !== 16'd0) begin
            n_fail++;
            $display("FAIL restart_clear: done=%b err=%b cnt=%0d want 0 0 0",
                     done, error, bit_count);
        end
        n_tests++;
        if (busy !== 1'b1 || ccff_shift_en !== 1'b1 || ccff_head !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_mark: busy=%b sh=%b head=%b want 1 1 0",
                     busy, ccff_shift_en, ccff_head);
        end
        pReset = 1'b1;
        step();
        pReset = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        bit h;
        run_load(0, 6, -1, h);
        n_tests++;
        if (h !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_reach: reached=%b want 1", h);
        end
        pReset = 1'b1;
        step();
        pReset = 1'b0;
        n_tests++;
        if ({s_ready, ccff_head, ccff_shift_en, busy, done, error} !== 6'b0
            || bit_count !== 16'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: rdy%b head%b sh%b busy%b done%b err%b cnt%0d want all 0",
                     s_ready, ccff_head, ccff_shift_en, busy, done, error, bit_count);
        end
        step();
        run_load(0, -1, -1, h);
        check_end("reload", 1'b0);
    endtask

    task automatic test_start_in_load();
        bit h;
        run_load(0, -1, 5, h);
        n_tests++;
        if (hseq[11:0] !== EXP_HSEQ || nshift != 12 || nstall != 0) begin
            n_fail++;
            $display("FAIL start_in_load: got %h (%0d shifts, %0d stalls) want %h (12, 0)",
                     hseq[11:0], nshift, nstall, EXP_HSEQ);
        end
        check_end("ign_start", 1'b0);
    endtask

    initial begin
        words[0] = 4'h3;
        words[1] = 4'hC;
        pReset   = 1'b1;
        start    = 1'b0;
        s_data   = 4'h0;
        s_valid  = 1'b0;
        test_reset();
        test_nominal();
        test_stalls();
        test_broken_chain();
        test_restart_in_done();
        test_reset_mid_load();
        test_start_in_load();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
